// File: rtl/mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arb                                                            |
// | Round-robin arbiter sharing one single-port memory between a fetch |
// | port and a data port, with fixed memory read latency MEM_LAT.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_arb #(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic          d_req,
  input  logic [AW-1:0] f_addr,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [DW-1:0] d_wdata,
  input  logic          hold,
  output logic          f_ack,
  output logic          d_ack,
  output logic [DW-1:0] f_rdata,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic       c_GNT_F = 1'b0;
  localparam logic       c_GNT_D = 1'b1;
  localparam logic [2:0] c_LAT   = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_last_gnt;
  logic          r_gnt;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic          r_f_ack;
  logic          r_d_ack;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_busy;

  logic          w_pick_d;
  logic          w_grant;
  logic [2:0]    w_cnt_inc;

  // Data wins when it is the only requester or when fetch was served last.
  assign w_pick_d  = d_req && (!f_req || (r_last_gnt == c_GNT_F));
  assign w_grant   = (r_state == S_IDLE) && !hold && (f_req || d_req);
  assign w_cnt_inc = r_cnt + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_last_gnt <= c_GNT_D;
      r_gnt      <= c_GNT_F;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_f_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_f_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt      <= w_pick_d;
            r_last_gnt <= w_pick_d;
            r_addr     <= w_pick_d ? d_addr : f_addr;
            r_we       <= w_pick_d && d_we;
            r_wdata    <= w_pick_d ? d_wdata : '0;
            r_mem_en   <= 1'b1;
            r_mem_we   <= w_pick_d && d_we;
            r_busy     <= 1'b1;
            r_state    <= S_ACC;
          end
        end
        S_ACC: begin
          r_cnt   <= 3'd1;
          r_state <= S_WAIT;
          // Acks are registered, so they are raised one cycle ahead of cnt==MEM_LAT.
          if (c_LAT == 3'd1) begin
            r_f_ack <= (r_gnt == c_GNT_F);
            r_d_ack <= (r_gnt == c_GNT_D);
          end
        end
        S_WAIT: begin
          if (r_cnt < c_LAT) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_LAT) begin
              r_f_ack <= (r_gnt == c_GNT_F);
              r_d_ack <= (r_gnt == c_GNT_D);
            end
          end else begin
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= 3'd0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign f_ack     = r_f_ack;
  assign d_ack     = r_d_ack;
  assign f_rdata   = r_f_ack ? mem_rdata : '0;
  assign d_rdata   = (r_d_ack && !r_we) ? mem_rdata : '0;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_mem_arb                                                         |
// | Directed bench for mem_arb at MEM_LAT=1 and MEM_LAT=3.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_arb;
  localparam int DW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, f_req, d_req, d_we, hold;
  logic [AW-1:0] f_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, f_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          f_ack, d_ack, mem_en, mem_we, busy;

  logic          rst3, f_req3;
  logic [AW-1:0] f_addr3, mem_addr3;
  logic [DW-1:0] f_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic          f_ack3, d_ack3, mem_en3, mem_we3, busy3;

  mem_arb #(.DW(DW), .AW(AW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .f_req(f_req), .d_req(d_req), .f_addr(f_addr),
    .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .hold(hold),
    .f_ack(f_ack), .d_ack(d_ack), .f_rdata(f_rdata), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arb #(.DW(DW), .AW(AW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .f_req(f_req3), .d_req(1'b0), .f_addr(f_addr3),
    .d_addr(16'h0000), .d_we(1'b0), .d_wdata(32'h0), .hold(1'b0),
    .f_ack(f_ack3), .d_ack(d_ack3), .f_rdata(f_rdata3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory model: word a holds 0xA5000000|a, except 0x10 holds 0xDEADBEEF.
  logic [DW-1:0] mem [256];
  logic          mem_init;
  logic [DW-1:0] p1;
  logic [DW-1:0] p3 [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hA500_0000 | DW'(i));
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    p1    <= mem_en  ? mem[mem_addr[7:0]]  : '0;
    p3[0] <= mem_en3 ? mem[mem_addr3[7:0]] : '0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata  = p1;
  assign mem_rdata3 = p3[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; hold = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    rst3 = 1'b1; f_req3 = 1'b0; f_addr3 = '0;
    mem_init = 1'b1;
    tick();
    tick();
    mem_init = 1'b0;

    check("rst_f_ack", 32'(f_ack), 0);
    check("rst_d_ack", 32'(d_ack), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_busy3", 32'(busy3), 0);

    // Single fetch, latency 1
    rst = 1'b0; f_req = 1'b1; f_addr = 16'h0010;
    check("f1_c1_busy", 32'(busy), 0);
    tick();
    check("f1_c2_mem_en", 32'(mem_en), 1);
    check("f1_c2_mem_addr", 32'(mem_addr), 32'h0010);
    check("f1_c2_mem_we", 32'(mem_we), 0);
    check("f1_c2_f_ack", 32'(f_ack), 0);
    tick();
    check("f1_c3_f_ack", 32'(f_ack), 1);
    check("f1_c3_f_rdata", f_rdata, 32'hDEADBEEF);
    check("f1_c3_d_ack", 32'(d_ack), 0);
    check("f1_c3_mem_en", 32'(mem_en), 0);
    f_req = 1'b0;
    tick();
    check("f1_c4_busy", 32'(busy), 0);
    check("f1_c4_f_ack", 32'(f_ack), 0);

    // Simultaneous requests after reset: fetch first
    rst = 1'b1;
    tick();
    rst = 1'b0; f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0020; d_addr = 16'h0030;
    tick();
    check("rr_c2_mem_addr", 32'(mem_addr), 32'h0020);
    tick();
    check("rr_c3_f_ack", 32'(f_ack), 1);
    check("rr_c3_d_ack", 32'(d_ack), 0);
    check("rr_c3_f_rdata", f_rdata, 32'hA5000020);
    f_req = 1'b0;
    tick();
    check("rr_c4_busy", 32'(busy), 0);
    tick();
    check("rr_c5_mem_en", 32'(mem_en), 1);
    check("rr_c5_mem_addr", 32'(mem_addr), 32'h0030);
    tick();
    check("rr_c6_d_ack", 32'(d_ack), 1);
    check("rr_c6_f_ack", 32'(f_ack), 0);
    check("rr_c6_d_rdata", d_rdata, 32'hA5000030);
    d_req = 1'b0;
    tick();

    // Both held for six transactions: F,D,F,D,F,D
    f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0040; d_addr = 16'h0050;
    for (int t = 0; t < 6; t++) begin
      logic exp_d;
      exp_d = t[0];
      tick();
      check($sformatf("alt%0d_mem_en", t), 32'(mem_en), 1);
      check($sformatf("alt%0d_mem_addr", t), 32'(mem_addr), exp_d ? 32'h0050 : 32'h0040);
      tick();
      check($sformatf("alt%0d_f_ack", t), 32'(f_ack), exp_d ? 0 : 1);
      check($sformatf("alt%0d_d_ack", t), 32'(d_ack), exp_d ? 1 : 0);
      check($sformatf("alt%0d_rdata", t), exp_d ? d_rdata : f_rdata,
            exp_d ? 32'hA5000050 : 32'hA5000040);
      if (t == 5) begin
        f_req = 1'b0; d_req = 1'b0;
      end
      tick();
      check($sformatf("alt%0d_idle_busy", t), 32'(busy), 0);
    end

    // Data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0004; d_wdata = 32'h12345678;
    tick();
    check("wr_c2_mem_en", 32'(mem_en), 1);
    check("wr_c2_mem_we", 32'(mem_we), 1);
    check("wr_c2_mem_addr", 32'(mem_addr), 32'h0004);
    check("wr_c2_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    check("wr_c3_d_ack", 32'(d_ack), 1);
    check("wr_c3_d_rdata", d_rdata, 32'h0);
    check("wr_c3_mem_en", 32'(mem_en), 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    d_req = 1'b1;
    tick();
    tick();
    check("rd_back_d_ack", 32'(d_ack), 1);
    check("rd_back_d_rdata", d_rdata, 32'h12345678);
    d_req = 1'b0;
    tick();

    // Hold blocks grants; toggling it mid-transaction has no effect
    hold = 1'b1; f_req = 1'b1; f_addr = 16'h0060;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold%0d_mem_en", k), 32'(mem_en), 0);
      check($sformatf("hold%0d_busy", k), 32'(busy), 0);
    end
    hold = 1'b0;
    tick();
    check("hold_rel_c2_mem_en", 32'(mem_en), 1);
    check("hold_rel_c2_f_ack", 32'(f_ack), 0);
    hold = 1'b1;
    tick();
    check("hold_rel_c3_f_ack", 32'(f_ack), 1);
    check("hold_rel_c3_f_rdata", f_rdata, 32'hA5000060);
    check("hold_rel_c3_d_ack", 32'(d_ack), 0);
    f_req = 1'b0; hold = 1'b0;
    tick();

    // MEM_LAT=3: reset during WAIT aborts, then retried
    rst3 = 1'b0; f_req3 = 1'b1; f_addr3 = 16'h0070;
    tick();
    check("l3_c2_mem_en", 32'(mem_en3), 1);
    tick();
    check("l3_c3_busy", 32'(busy3), 1);
    check("l3_c3_f_ack", 32'(f_ack3), 0);
    rst3 = 1'b1;
    tick();
    check("l3_rst_busy", 32'(busy3), 0);
    check("l3_rst_mem_en", 32'(mem_en3), 0);
    check("l3_rst_f_ack", 32'(f_ack3), 0);
    rst3 = 1'b0;
    tick();
    check("l3_re_c2_mem_en", 32'(mem_en3), 1);
    check("l3_re_c2_f_ack", 32'(f_ack3), 0);
    tick();
    check("l3_re_c3_f_ack", 32'(f_ack3), 0);
    tick();
    check("l3_re_c4_f_ack", 32'(f_ack3), 0);
    tick();
    check("l3_re_c5_f_ack", 32'(f_ack3), 1);
    check("l3_re_c5_f_rdata", f_rdata3, 32'hA5000070);
    f_req3 = 1'b0;
    tick();
    check("l3_after_f_ack", 32'(f_ack3), 0);
    check("l3_after_busy", 32'(busy3), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The module SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 The module SHALL have parameter AW, default 16, meaning address width in bits.
REQ-003 The module SHALL have parameter MEM_LAT, default 1, legal 1..4, meaning cycles from the mem_en cycle to mem_rdata valid.
REQ-004 The module SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The module SHALL have ports f_req/d_req  input  1 each  fetch and data access request, held high until the matching ack.
REQ-007 The module SHALL have ports f_addr/d_addr  input  AW each  request address, stable while the request is pending.
REQ-008 The module SHALL have port d_we  input  1  data-port write (1) or read (0), stable while d_req is pending.
REQ-009 The module SHALL have port d_wdata  input  DW  data-port write data.
REQ-010 The module SHALL have port hold  input  1  blocks new grants; driven by the HLT decode.
REQ-011 The module SHALL have ports f_ack/d_ack  output  1 each  one-cycle completion pulse.
REQ-012 The module SHALL have ports f_rdata/d_rdata  output  DW each  read data, valid only in the cycle of the matching ack.
REQ-013 The module SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, AW), mem_wdata (output, DW) and mem_rdata (input, DW)  single-port memory interface.
REQ-014 The module SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACC, WAIT.
REQ-016 In IDLE with hold=0 and at least one request high, the module SHALL latch the winner, its address, its we and its wdata, then move to ACC.
REQ-017 If exactly one request is high, that port SHALL win.
REQ-018 If both requests are high, the port opposite to last_gnt SHALL win (round robin), and last_gnt SHALL update to the winner.
REQ-019 In IDLE with hold=1, the module SHALL issue no grant; a pending request SHALL remain unserved until hold falls.
REQ-020 ACC SHALL last exactly one cycle, with mem_en=1, mem_addr/mem_we/mem_wdata from the latched values, and mem_we=0 for fetch; the FSM SHALL then load cnt=1 and go to WAIT.
REQ-021 WAIT SHALL increment cnt each cycle while cnt<MEM_LAT.
REQ-022 When cnt==MEM_LAT, the module SHALL pulse the winner's ack for that cycle only, route mem_rdata to that port's rdata (zero for writes and for the other port), and return to IDLE.
REQ-023 Request-to-ack latency for an uncontended request SHALL be MEM_LAT+2 cycles, measured from the cycle req is first sampled high in IDLE to the ack cycle.
REQ-024 Outside ACC, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-025 A new request sampled in the cycle right after ack SHALL be arbitrated normally, with no dead cycle beyond IDLE.
REQ-026 Requests and hold changing during ACC or WAIT SHALL not affect the transaction in flight.
REQ-027 The module SHALL never assert f_ack and d_ack in the same cycle.

Reset
REQ-028 On rst=1 at a rising edge, the module SHALL set state=IDLE, cnt=0, last_gnt=data (so fetch wins the first contention), and f_ack=d_ack=mem_en=mem_we=busy=0.
REQ-029 Reset during ACC or WAIT SHALL abort the transaction with no ack; the requester keeps req high and is re-arbitrated after reset releases.

Verification
REQ-030 Scenario: MEM_LAT=1, reset, then f_req with f_addr=0x0010 and mem model returning 0xDEADBEEF -> mem_en high in cycle 2, f_ack and f_rdata=0xDEADBEEF in cycle 3, busy low in cycle 4.
REQ-031 Scenario: f_req and d_req rise together after reset, held for two transactions -> fetch is served first, then data; last_gnt=data at end; acks are never simultaneous.
REQ-032 Scenario: d_req with d_we=1, d_addr=0x0004, d_wdata=0x12345678 -> one mem_en cycle with mem_we=1 and matching address and data; d_ack pulses; d_rdata=0.
REQ-033 Scenario: hold=1 with f_req high for 5 cycles, then hold=0 -> no mem_en while hold is high; f_ack exactly MEM_LAT+2 cycles after hold falls.
REQ-034 Scenario: MEM_LAT=3, rst pulsed during WAIT -> no ack; after release the request completes with ack 5 cycles after re-sampling.
REQ-035 Scenario: both requests held high continuously for 6 transactions -> grants alternate F,D,F,D,F,D with no idle gap beyond one IDLE cycle per transaction.
